// File: rtl/channel_arbiter.sv
// Round-robin arbiter sharing one valid/ready consumer between NUM_CH two-phase token channels.
// A channel is granted for GRANT_LEN cycles, acknowledges by dropping its request, and its data is then forwarded.
module channel_arbiter #(
   parameter  int NUM_CH    = 4,
   parameter  int data_size = 8,
   parameter  int GRANT_LEN = 2,
   parameter  int TIMEOUT   = 16,
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH-1:0]           ch_request,
   input  logic [NUM_CH*data_size-1:0] ch_data,
   output logic [NUM_CH-1:0]           ch_grant,
   output logic                        o_valid,
   input  logic                        o_ready,
   output logic [data_size-1:0]        o_data,
   output logic [CH_W-1:0]             o_ch,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT_ACK,
      S_CAPTURE,
      S_OUT
   } state_t;

   state_t              state, state_d;
   logic [NUM_CH-1:0]   req_m, req_s;
   logic [CH_W-1:0]     sel, sel_d, ptr, ptr_d, next_ptr, rr_sel;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                rr_any, timeout_hit;
   logic [NUM_CH-1:0]   grant_d;
   logic                valid_d, busy_d, terr_d;

   // Lowest requesting index at or above start, wrapping modulo NUM_CH.
   function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   start);
      logic [CH_W:0]   sum;
      logic [CH_W-1:0] idx;
      rr_pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         sum = {1'b0, start} + (CH_W+1)'(i);
         if (sum >= (CH_W+1)'(NUM_CH))
            sum = sum - (CH_W+1)'(NUM_CH);
         idx = sum[CH_W-1:0];
         if (req[idx])
            rr_pick = idx;
      end
   endfunction

   // Requests come from another clock domain; only the second flop is ever looked at.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_m <= '0;
         req_s <= '0;
      end else begin
         req_m <= ch_request;
         req_s <= req_m;
      end
   end

   assign rr_any   = |req_s;
   assign rr_sel   = rr_pick(req_s, ptr);
   assign next_ptr = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;

   // State register, together with the datapath registers and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         sel         <= '0;
         ptr         <= '0;
         cnt         <= '0;
         ch_grant    <= '0;
         o_valid     <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         o_data      <= '0;
         o_ch        <= '0;
      end else begin
         state       <= state_d;
         sel         <= sel_d;
         ptr         <= ptr_d;
         cnt         <= cnt_d;
         ch_grant    <= grant_d;
         o_valid     <= valid_d;
         busy        <= busy_d;
         timeout_err <= terr_d;
         if (state == S_CAPTURE) begin
            o_data <= ch_data[sel*data_size +: data_size];
            o_ch   <= sel;
         end
      end
   end

   // NOTE: every variable gets a default at the top so no path can leave one unassigned (no latches).
   always_comb begin
      state_d     = state;
      sel_d       = sel;
      ptr_d       = ptr;
      cnt_d       = cnt;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (rr_any) begin
               sel_d   = rr_sel;
               cnt_d   = CNT_W'(GRANT_LEN);
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (cnt == CNT_W'(1)) begin
               cnt_d   = CNT_W'(TIMEOUT);
               state_d = S_WAIT_ACK;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (!req_s[sel]) begin
               state_d = S_CAPTURE;
            end else if (cnt == '0) begin
               ptr_d       = next_ptr;
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         S_CAPTURE: state_d = S_OUT;
         S_OUT: begin
            if (o_ready) begin
               ptr_d   = next_ptr;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state, so the registered outputs line up with the state they describe.
   always_comb begin
      grant_d = '0;
      if (state_d == S_GRANT)
         grant_d[sel_d] = 1'b1;
      valid_d = (state_d == S_OUT);
      busy_d  = (state_d != S_IDLE);
      terr_d  = timeout_hit;
   end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed and random bench for channel_arbiter with behavioural two-phase channel models and a scoreboard.
module tb_channel_arbiter;

   localparam int NUM_CH    = 4;
   localparam int DW        = 8;
   localparam int GRANT_LEN = 2;
   localparam int TIMEOUT   = 16;
   localparam int CH_W      = $clog2(NUM_CH);

   typedef struct {
      int          ch;
      logic [7:0]  data;
   } token_t;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NUM_CH-1:0]      ch_request;
   logic [NUM_CH*DW-1:0]   ch_data;
   logic [NUM_CH-1:0]      ch_grant;
   logic                   o_valid;
   logic                   o_ready = 1'b1;
   logic [DW-1:0]          o_data;
   logic [CH_W-1:0]        o_ch;
   logic                   busy;
   logic                   timeout_err;

   int          fill_seq [NUM_CH] = '{default: 0};
   int          ack_seq  [NUM_CH] = '{default: 0};
   logic [7:0]  fill_val [NUM_CH] = '{default: 8'h00};
   logic        ign      [NUM_CH] = '{default: 1'b0};

   token_t      exp_q[$];
   int          out_log[$];
   int          grant_log[$];
   int          checks = 0;
   int          errors = 0;
   int          timeout_cnt = 0;
   logic [NUM_CH-1:0] prev_grant = '0;
   int          gwidth = 0;
   int          since = 0;
   logic        prev_terr = 1'b0;

   channel_arbiter #(
      .NUM_CH(NUM_CH), .data_size(DW), .GRANT_LEN(GRANT_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_request(ch_request), .ch_data(ch_data),
      .ch_grant(ch_grant), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .o_ch(o_ch), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // A channel requests while it holds an unacknowledged fill.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ch_request[k]         = (fill_seq[k] != ack_seq[k]);
         ch_data[k*DW +: DW]   = fill_val[k];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NUM_CH-1:0] v);
      onehot_idx = -1;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (v[k]) onehot_idx = k;
   endfunction

   function automatic bit pending(input int k);
      pending = 1'b0;
      foreach (exp_q[i])
         if (exp_q[i].ch == k) pending = 1'b1;
   endfunction

   // Channel model, grant monitor and scoreboard, evaluated on every falling edge.
   task automatic sample();
      int idx;
      for (int k = 0; k < NUM_CH; k++)
         if (ch_grant[k] && !ign[k]) ack_seq[k] = fill_seq[k];
      if (!rst_n) begin
         prev_grant = '0;
         gwidth     = 0;
         since      = 0;
         prev_terr  = 1'b0;
         return;
      end
      if (ch_grant != '0) begin
         check("grant_onehot", $countones(ch_grant), 1);
         if (prev_grant == '0) begin
            grant_log.push_back(onehot_idx(ch_grant));
            gwidth = 1;
         end else begin
            gwidth++;
         end
      end else if (prev_grant != '0) begin
         check("grant_width", gwidth, GRANT_LEN);
         since = 0;
      end else begin
         since++;
      end
      if (timeout_err) begin
         timeout_cnt++;
         check("timeout_delay", since, TIMEOUT + 1);
         check("timeout_single", prev_terr, 0);
      end
      prev_terr = timeout_err;
      if (o_valid && o_ready) begin
         idx = -1;
         foreach (exp_q[i])
            if (idx < 0 && exp_q[i].ch == int'(o_ch)) idx = i;
         check("out_expected", idx >= 0, 1);
         if (idx >= 0) begin
            check("out_data", o_data, exp_q[idx].data);
            exp_q.delete(idx);
         end
         out_log.push_back(int'(o_ch));
      end
      prev_grant = ch_grant;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int k, input logic [7:0] d, input logic ignore);
      token_t t;
      fill_val[k] = d;
      ign[k]      = ignore;
      fill_seq[k] = fill_seq[k] + 1;
      if (!ignore) begin
         t.ch   = k;
         t.data = d;
         exp_q.push_back(t);
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy || ch_request != '0) && n < budget) begin
         tick();
         n++;
      end
      for (int i = 0; i < 3; i++) tick();
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic check_order(input string tag, input int n, input int e0, input int e1,
                              input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      check({tag, "_count"}, out_log.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_%0d", tag, i), (i < out_log.size()) ? out_log[i] : -1, e[i]);
   endtask

   initial begin
      int n;
      int fills;
      int k;

      // Reset values
      tick();
      tick();
      check("rst_grant", ch_grant, 0);
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_ch", o_ch, 0);
      check("rst_busy", busy, 0);
      check("rst_terr", timeout_err, 0);
      rst_n = 1'b1;
      tick();
      tick();

      // All four channels at once from ptr=0, then ch0 and ch3 again
      out_log.delete();
      fill(0, 8'h10, 1'b0);
      fill(1, 8'h21, 1'b0);
      fill(2, 8'h32, 1'b0);
      fill(3, 8'h43, 1'b0);
      drain("simul", 400);
      check_order("simul_order", 4, 0, 1, 2, 3);
      out_log.delete();
      fill(0, 8'h5A, 1'b0);
      fill(3, 8'hC3, 1'b0);
      drain("reuse", 200);
      check_order("reuse_order", 2, 0, 3, 0, 0);

      // Single request on ch2, then ptr=3 makes ch3 win over ch0
      out_log.delete();
      fill(2, 8'hA5, 1'b0);
      n = 0;
      while (ch_grant == '0 && n < 20) begin tick(); n++; end
      check("single_grant", ch_grant, 4'b0100);
      drain("single", 100);
      check_order("single_order", 1, 2, 0, 0, 0);
      out_log.delete();
      fill(0, 8'h01, 1'b0);
      fill(3, 8'h03, 1'b0);
      drain("ptr3", 200);
      check_order("ptr3_order", 2, 3, 0, 0, 0);

      // Backpressure: OUT held with o_ready low, a second request must wait
      out_log.delete();
      o_ready = 1'b0;
      fill(1, 8'h3C, 1'b0);
      n = 0;
      while (!o_valid && n < 50) begin tick(); n++; end
      check("bp_valid_seen", o_valid, 1);
      fill(2, 8'h77, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", o_valid, 1);
         check("bp_data", o_data, 8'h3C);
         check("bp_ch", o_ch, 1);
         check("bp_no_grant", ch_grant, 0);
      end
      o_ready = 1'b1;
      drain("bp", 200);
      check_order("bp_order", 2, 1, 2, 0, 0);

      // Timeout: ch0 never acknowledges, ch1 must be served next
      out_log.delete();
      grant_log.delete();
      fill(0, 8'h11, 1'b1);
      fill(1, 8'h22, 1'b0);
      n = 0;
      while (timeout_cnt == 0 && n < 200) begin tick(); n++; end
      check("timeout_seen", timeout_cnt, 1);
      fill_seq[0] = ack_seq[0];
      ign[0]      = 1'b0;
      drain("timeout", 200);
      check("timeout_count", timeout_cnt, 1);
      check("timeout_grants", grant_log.size(), 2);
      check("timeout_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
      check("timeout_next", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
      check_order("timeout_order", 1, 1, 0, 0, 0);

      // Asynchronous reset while ch1 is granted
      out_log.delete();
      fill(1, 8'h55, 1'b0);
      n = 0;
      while (!ch_grant[1] && n < 50) begin tick(); n++; end
      check("mid_grant_seen", ch_grant[1], 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant", ch_grant, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", o_valid, 0);
      fill(3, 8'h66, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      grant_log.delete();
      out_log.delete();
      drain("post_rst", 200);
      check_order("post_rst_order", 2, 1, 3, 0, 0);

      // Random fills with random backpressure
      fills = 0;
      n = 0;
      while (fills < 20 && n < 4000) begin
         o_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(0, NUM_CH - 1));
            if (!pending(k) && !ch_request[k]) begin
               fill(k, 8'($urandom_range(0, 255)), 1'b0);
               fills++;
            end
         end
         tick();
         n++;
      end
      o_ready = 1'b1;
      check("rand_fills", fills, 20);
      drain("rand", 1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
